// File: rtl/div_seq_pkg.sv
// Shared types and constants for the div_seq sequential divider.
// Signed operation is enabled by defining DIV_SEQ_SIGNED_EN.
package div_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // The iteration counter has to reach WIDTH-1.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring division step: trial subtract of the divisor from
// the shifted partial remainder, keep the difference when it does not underflow.
module div_seq_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   part_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    // Quotient bit and restored or reduced remainder.
    always_comb begin
        qbit_o = (part_i >= {1'b0, divisor_i});
        if (qbit_o) begin
            rem_o = part_i[WIDTH-1:0] - divisor_i;
        end else begin
            rem_o = part_i[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Fixed-latency sequential divider: one restoring step per cycle.
// Define DIV_SEQ_SIGNED_EN to honour signed_op; otherwise all operations are unsigned.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t           state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_raw_q, dvs_raw_q;
    logic [WIDTH-1:0] acc_q, rem_q, dvs_q;
    logic             neg_quo_q, neg_rem_q, dbz_flag_q, ovf_flag_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q, ovf_q;
    logic             dvd_neg_s, dvs_neg_s, ovf_s;
    logic [WIDTH-1:0] rem_nxt_s, fix_quo_s, fix_rem_s;
    logic             qbit_s;

`ifdef DIV_SEQ_SIGNED_EN
    logic op_signed_q;

    // Remember the operation mode at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_signed_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            op_signed_q <= signed_op;
        end
    end

    assign dvd_neg_s = op_signed_q & dvd_raw_q[WIDTH-1];
    assign dvs_neg_s = op_signed_q & dvs_raw_q[WIDTH-1];
    assign ovf_s     = op_signed_q & (dvd_raw_q == MIN_NEG) & (dvs_raw_q == ALL_ONES);
`else
    assign dvd_neg_s = signed_op & 1'b0;
    assign dvs_neg_s = 1'b0;
    assign ovf_s     = 1'b0;
`endif

    div_seq_step #(.WIDTH(WIDTH)) u_step (
        .part_i    ({rem_q, acc_q[WIDTH-1]}),
        .divisor_i (dvs_q),
        .rem_o     (rem_nxt_s),
        .qbit_o    (qbit_s)
    );

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: state_d = S_ITER;
            S_ITER: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so they can be registered.
    always_comb begin
        busy_d = 1'b1;
        done_d = 1'b0;
        case (state_d)
            S_IDLE:  busy_d = 1'b0;
            S_DONE:  done_d = 1'b1;
            default: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
        endcase
    end

    // Sign correction and the divide-by-zero / overflow overrides.
    always_comb begin
        fix_quo_s = neg_if(neg_quo_q, acc_q);
        fix_rem_s = neg_if(neg_rem_q, rem_q);
        if (dbz_flag_q) begin
            fix_quo_s = ALL_ONES;
            fix_rem_s = dvd_raw_q;
        end else if (ovf_flag_q) begin
            fix_quo_s = MIN_NEG;
            fix_rem_s = {WIDTH{1'b0}};
        end else begin
            fix_quo_s = neg_if(neg_quo_q, acc_q);
            fix_rem_s = neg_if(neg_rem_q, rem_q);
        end
    end

    // Datapath: capture, magnitude prep, shift/subtract iterations, result update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= {CW{1'b0}};
            dvd_raw_q   <= {WIDTH{1'b0}};
            dvs_raw_q   <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_flag_q  <= 1'b0;
            ovf_flag_q  <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dvd_raw_q <= dividend;
                        dvs_raw_q <= divisor;
                        dbz_q     <= 1'b0;
                        ovf_q     <= 1'b0;
                    end
                end
                S_PREP: begin
                    acc_q      <= neg_if(dvd_neg_s, dvd_raw_q);
                    dvs_q      <= neg_if(dvs_neg_s, dvs_raw_q);
                    rem_q      <= {WIDTH{1'b0}};
                    cnt_q      <= {CW{1'b0}};
                    neg_quo_q  <= dvd_neg_s ^ dvs_neg_s;
                    neg_rem_q  <= dvd_neg_s;
                    dbz_flag_q <= (dvs_raw_q == {WIDTH{1'b0}});
                    ovf_flag_q <= ovf_s;
                end
                S_ITER: begin
                    acc_q <= {acc_q[WIDTH-2:0], qbit_s};
                    rem_q <= rem_nxt_s;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    quotient_q  <= fix_quo_s;
                    remainder_q <= fix_rem_s;
                    dbz_q       <= dbz_flag_q;
                    ovf_q       <= ovf_flag_q & ~dbz_flag_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table + scoreboard on a 32-bit
// instance, hand sequences for reset, held start and an 8-bit instance.
module tb_div_seq;

    localparam int W = 32;

    typedef struct {
        logic        sg;
        logic [31:0] a, b, q, r;
        logic        dbz, ovf;
    } vec_t;

    typedef struct {
        logic [31:0] q, r;
        logic        dbz, ovf;
        int          acc;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        start = 1'b0, signed_op = 1'b0;
    logic [31:0] dividend = 32'd0, divisor = 32'd0;
    logic        busy, done, dbz, ovf;
    logic [31:0] quotient, remainder;

    logic        s8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        busy8, done8, dbz8, ovf8;
    logic [7:0]  q8, r8;

    exp_t        sbq[$];
    vec_t        vt[$];
    int          errors = 0, checks = 0, cyc = 0;
    logic [31:0] last_q = 32'd0, last_r = 32'd0;

    div_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .dbz(dbz), .ovf(ovf)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .signed_op(sg8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .dbz(dbz8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic sg_in, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        sg;
        logic signed [31:0] sa, sbv;
        sg = sg_in;
`ifndef DIV_SEQ_SIGNED_EN
        sg = 1'b0;
`endif
        e.acc = 0; e.dbz = 1'b0; e.ovf = 1'b0;
        sa = a; sbv = b;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.ovf = 1'b1;
        end else if (sg) begin
            e.q = sa / sbv; e.r = sa % sbv;
        end else begin
            e.q = a / b; e.r = a % b;
        end
        return e;
    endfunction

    // Scoreboard monitor: every done pulse pops one expectation; results hold while busy.
    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("dbz", dbz, e.dbz);
                chk("ovf", ovf, e.ovf);
                chk("latency", cyc - e.acc, W + 2);
                last_q = quotient;
                last_r = remainder;
            end
        end else if (reset && busy) begin
            chk("quotient_hold", quotient, last_q);
            chk("remainder_hold", remainder, last_r);
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic do_op(input vec_t v, input bit noisy);
        exp_t e;
        wait_idle();
        signed_op = v.sg; dividend = v.a; divisor = v.b; start = 1'b1;
        e.q = v.q; e.r = v.r; e.dbz = v.dbz; e.ovf = v.ovf; e.acc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        chk("flags_cleared", {dbz, ovf}, 2'b00);
        if (noisy) begin
            dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom_range(1));
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            dividend = $urandom; divisor = $urandom;
        end
    endtask

    task automatic add(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ov);
        vec_t v;
        v.sg = sg; v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dz; v.ovf = ov;
        vt.push_back(v);
    endtask

    task automatic run8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r);
        int acc;
        while (busy8 !== 1'b0 && cyc < 90000) @(negedge clk);
        sg8 = sg; a8 = a; b8 = b; s8 = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        s8 = 1'b0;
        while (cyc < acc + 9) @(negedge clk);
        chk("w8_done_early", done8, 1'b0);
        @(negedge clk);
        chk("w8_done", done8, 1'b1);
        chk("w8_quotient", q8, q);
        chk("w8_remainder", r8, r);
    endtask

    initial begin
        vec_t v;
        exp_t e;
        int   t;
        int   acc1;

        add(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        add(1'b0, 32'h12, 32'd0, 32'hFFFF_FFFF, 32'h12, 1'b1, 1'b0);
        add(1'b1, 32'h12, 32'd0, 32'hFFFF_FFFF, 32'h12, 1'b1, 1'b0);
        add(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        add(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        add(1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 1'b0);
        add(1'b0, 32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0, 1'b0);
        add(1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0);
`ifdef DIV_SEQ_SIGNED_EN
        add(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        add(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
        add(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        add(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
`else
        add(1'b1, 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0, 1'b0);
        add(1'b1, 32'd100, 32'hFFFF_FFF9, 32'd0, 32'd100, 1'b0, 1'b0);
        add(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        add(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFF9, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 8; i++) begin
            v.sg = 1'($urandom_range(1));
            v.a  = $urandom;
            v.b  = (i < 4) ? ($urandom >> $urandom_range(31)) : $urandom_range(255);
            e    = model(v.sg, v.a, v.b);
            v.q = e.q; v.r = e.r; v.dbz = e.dbz; v.ovf = e.ovf;
            vt.push_back(v);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_flags", {dbz, ovf}, 2'b00);
        reset = 1'b1;

        foreach (vt[i]) do_op(vt[i], (i % 2) == 1);
        add(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b0);
        do_op(vt[vt.size()-1], 1'b0);

        // Reset in the middle of iterating: abandon the op, clear everything at once.
        wait_idle();
        while (sbq.size() != 0 && cyc < 90000) @(negedge clk);
        @(negedge clk);
        chk("pre_reset_quotient_nonzero", (quotient != 32'd0), 1'b1);
        signed_op = 1'b0; dividend = 32'd12345; divisor = 32'd67; start = 1'b1;
        acc1 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc1 + 12) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_flags", {dbz, ovf}, 2'b00);
        last_q = 32'd0; last_r = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        v.sg = 1'b0; v.a = 32'd12345; v.b = 32'd67; v.q = 32'd184; v.r = 32'd17; v.dbz = 1'b0; v.ovf = 1'b0;
        do_op(v, 1'b1);

        // Start held high: back-to-back accepts every W+4 cycles.
        wait_idle();
        signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
        acc1 = cyc + 1;
        e.q = 32'd142; e.r = 32'd6; e.dbz = 1'b0; e.ovf = 1'b0;
        e.acc = acc1;      sbq.push_back(e);
        e.acc = acc1 + 36; sbq.push_back(e);
        while (cyc < acc1 + 35) @(negedge clk);
        chk("b2b_idle_gap", busy, 1'b0);
        @(negedge clk);
        chk("b2b_reaccept", busy, 1'b1);
        start = 1'b0;

        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        repeat (3) @(negedge clk);

        run8(1'b0, 8'd200, 8'd3, 8'd66, 8'd2);
`ifdef DIV_SEQ_SIGNED_EN
        run8(1'b1, 8'hF0, 8'h02, 8'hF8, 8'd0);
`else
        run8(1'b1, 8'hF0, 8'h02, 8'd120, 8'd0);
`endif
        chk("w8_flags", {dbz8, ovf8}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
